bird_flap_physics: RTL and testbench



---
 rtl/bird_flap_physics.sv | 161 ++++++++++++++++
 tb/tb_bird_flap_physics.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/bird_flap_physics.sv
// Bird vertical physics and game-state tracker: turns debounced flap presses into
// impulses, integrates velocity/position on each frame tick, and reports play/death state.
module bird_flap_physics #(
    parameter int Y_WIDTH  = 10,
    parameter int Y_START  = 240,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 463,
    parameter int V_WIDTH  = 6,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = 8,
    parameter int VEL_MAX  = 12
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic                      i_Button,
    input  logic                      i_Tick,
    input  logic                      i_Collision,
    output logic [Y_WIDTH-1:0]        o_Bird_Y,
    output logic signed [V_WIDTH-1:0] o_Velocity,
    output logic                      o_Flap_Pulse,
    output logic                      o_Playing,
    output logic                      o_Game_Over
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLYING = 2'd1;
    localparam logic [1:0] ST_DEAD   = 2'd2;

    localparam int YW2 = Y_WIDTH + 2;

    localparam logic [Y_WIDTH-1:0]        Y_START_C = Y_WIDTH'(Y_START);
    localparam logic [Y_WIDTH-1:0]        Y_MIN_C   = Y_WIDTH'(Y_MIN);
    localparam logic [Y_WIDTH-1:0]        Y_MAX_C   = Y_WIDTH'(Y_MAX);
    localparam logic signed [YW2-1:0]     Y_MIN_X   = YW2'(Y_MIN);
    localparam logic signed [YW2-1:0]     Y_MAX_X   = YW2'(Y_MAX);
    localparam logic signed [V_WIDTH:0]   GRAV_C    = (V_WIDTH+1)'(GRAVITY);
    localparam logic signed [V_WIDTH:0]   VMAX_C    = (V_WIDTH+1)'(VEL_MAX);
    localparam logic signed [V_WIDTH-1:0] FLAP_C    = V_WIDTH'(-FLAP_VEL);
    localparam logic signed [V_WIDTH-1:0] V_ZERO    = '0;

    logic [1:0]                state_q, state_d;
    logic [Y_WIDTH-1:0]        y_q, y_d;
    logic signed [V_WIDTH-1:0] v_q, v_d;
    logic                      pending_q, pending_d;
    logic                      prev_q;
    logic                      pulse_q;
    logic                      playing_q;
    logic                      game_over_q;

    logic                      edge_s;
    logic                      flap_s;
    logic signed [V_WIDTH:0]   v_inc_s;
    logic signed [V_WIDTH-1:0] v_next_s;
    logic signed [YW2-1:0]     y_next_s;

    // Edge detect and one tick of the physics model, computed every cycle.
    always_comb begin
        edge_s  = i_Button & ~prev_q;
        flap_s  = pending_q | edge_s;
        // One extra bit so v + GRAVITY cannot wrap before the terminal-velocity clamp.
        v_inc_s = $signed({v_q[V_WIDTH-1], v_q}) + GRAV_C;
        if (flap_s) begin
            v_next_s = FLAP_C;
        end else if (v_inc_s > VMAX_C) begin
            v_next_s = VMAX_C[V_WIDTH-1:0];
        end else begin
            v_next_s = v_inc_s[V_WIDTH-1:0];
        end
        y_next_s = $signed({2'b00, y_q})
                 + $signed({{(YW2-V_WIDTH){v_next_s[V_WIDTH-1]}}, v_next_s});
    end

    // Game state machine with position/velocity next-state selection.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        v_d       = v_q;
        pending_d = pending_q;
        case (state_q)
            ST_IDLE: begin
                y_d = Y_START_C;
                v_d = V_ZERO;
                if (edge_s) begin
                    state_d   = ST_FLYING;
                    pending_d = 1'b1;
                end else begin
                    pending_d = 1'b0;
                end
            end
            ST_FLYING: begin
                if (i_Collision) begin
                    state_d   = ST_DEAD;
                    pending_d = 1'b0;
                end else if (i_Tick) begin
                    pending_d = 1'b0;
                    if (y_next_s <= Y_MIN_X) begin
                        y_d = Y_MIN_C;
                        v_d = V_ZERO;
                    end else if (y_next_s >= Y_MAX_X) begin
                        y_d     = Y_MAX_C;
                        v_d     = V_ZERO;
                        state_d = ST_DEAD;
                    end else begin
                        y_d = y_next_s[Y_WIDTH-1:0];
                        v_d = v_next_s;
                    end
                end else if (edge_s) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
            end
            ST_DEAD: begin
                if (edge_s) begin
                    state_d   = ST_IDLE;
                    y_d       = Y_START_C;
                    v_d       = V_ZERO;
                    pending_d = 1'b0;
                end else begin
                    pending_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                y_d       = Y_START_C;
                v_d       = V_ZERO;
                pending_d = 1'b0;
            end
        endcase
    end

    // State, physics and registered output decode; button history resets high.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= ST_IDLE;
            y_q         <= Y_START_C;
            v_q         <= V_ZERO;
            pending_q   <= 1'b0;
            prev_q      <= 1'b1;
            pulse_q     <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            v_q         <= v_d;
            pending_q   <= pending_d;
            prev_q      <= i_Button;
            pulse_q     <= edge_s;
            playing_q   <= (state_d == ST_FLYING);
            game_over_q <= (state_d == ST_DEAD);
        end
    end

    assign o_Bird_Y     = y_q;
    assign o_Velocity   = v_q;
    assign o_Flap_Pulse = pulse_q;
    assign o_Playing    = playing_q;
    assign o_Game_Over  = game_over_q;

endmodule

// File: tb/tb_bird_flap_physics.sv
// Directed bench for bird_flap_physics: hand-computed trajectories, clamps,
// flap collapsing, collision and restart sequencing.
module tb_bird_flap_physics;

    logic              clk = 1'b0;
    logic              rst;
    logic              button;
    logic              tick;
    logic              collision;
    logic [9:0]        bird_y;
    logic signed [5:0] velocity;
    logic              flap_pulse;
    logic              playing;
    logic              game_over;

    int vec_cnt = 0;
    int err_cnt = 0;

    bird_flap_physics dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_Button     (button),
        .i_Tick       (tick),
        .i_Collision  (collision),
        .o_Bird_Y     (bird_y),
        .o_Velocity   (velocity),
        .o_Flap_Pulse (flap_pulse),
        .o_Playing    (playing),
        .o_Game_Over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_yv(input string tag, input int exp_y, input int exp_v);
        chk({tag, "_y"}, int'(bird_y), exp_y);
        chk({tag, "_v"}, int'(velocity), exp_v);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic press();
        button = 1'b1;
        step();
        button = 1'b0;
        step();
    endtask

    task automatic flap_tick();
        button = 1'b1;
        tick   = 1'b1;
        step();
        button = 1'b0;
        tick   = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; button = 1'b1; tick = 1'b0; collision = 1'b0;
        repeat (3) step();
        chk_yv("reset", 240, 0);
        chk("reset_pulse", int'(flap_pulse), 0);
        chk("reset_playing", int'(playing), 0);
        chk("reset_gameover", int'(game_over), 0);

        // Button held through reset: no flap.
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_pulse", int'(flap_pulse), 0);
            chk("held_playing", int'(playing), 0);
        end
        button = 1'b0;
        step();
        chk("release_pulse", int'(flap_pulse), 0);
        button = 1'b1;
        step();
        chk("press_pulse", int'(flap_pulse), 1);
        chk("press_playing", int'(playing), 1);
        button = 1'b0;
        step();
        chk("press_pulse_end", int'(flap_pulse), 0);

        // First tick uses the pending flap, then gravity.
        do_tick(); chk_yv("t1", 232, -8);
        do_tick(); chk_yv("t2", 225, -7);
        do_tick(); chk_yv("t3", 219, -6);
        do_tick(); chk_yv("t4", 214, -5);

        // Several presses plus a same-cycle press collapse to a single flap.
        press(); press(); press();
        chk_yv("no_tick_hold", 214, -5);
        flap_tick();
        chk_yv("multi_flap", 206, -8);
        do_tick();
        chk_yv("after_multi", 199, -7);

        // Climb to the ceiling.
        for (int i = 0; i < 24; i++) flap_tick();
        chk_yv("climb", 7, -8);
        flap_tick();
        chk_yv("ceiling_clamp", 0, 0);
        chk("ceiling_playing", int'(playing), 1);
        do_tick(); chk_yv("fall1", 1, 1);
        do_tick(); chk_yv("fall2", 3, 2);
        flap_tick();
        chk_yv("ceiling_flap_clamp", 0, 0);
        chk("ceiling2_playing", int'(playing), 1);

        // Free fall from Y=0, v=0 to the ground.
        for (int i = 1; i <= 44; i++) begin
            do_tick();
            chk("fall_v", int'(velocity), (i < 12) ? i : 12);
        end
        chk_yv("fall_end", 462, 12);
        chk("fall_playing", int'(playing), 1);
        do_tick();
        chk_yv("ground", 463, 0);
        chk("ground_gameover", int'(game_over), 1);
        chk("ground_playing", int'(playing), 0);

        // Dead: ticks and collision ignored.
        collision = 1'b1;
        do_tick(); do_tick();
        collision = 1'b0;
        chk_yv("dead_hold", 463, 0);
        chk("dead_gameover", int'(game_over), 1);
        press();
        chk_yv("restart_idle", 240, 0);
        chk("restart_gameover", int'(game_over), 0);
        chk("restart_playing", int'(playing), 0);
        do_tick();
        chk_yv("idle_tick", 240, 0);
        chk("idle_tick_playing", int'(playing), 0);
        press();
        chk("refly_playing", int'(playing), 1);
        do_tick();
        chk_yv("refly_t1", 232, -8);

        // Collision wins over a same-cycle tick.
        collision = 1'b1; tick = 1'b1;
        step();
        collision = 1'b0; tick = 1'b0;
        chk_yv("collide", 232, -8);
        chk("collide_gameover", int'(game_over), 1);
        do_tick();
        chk_yv("collide_hold", 232, -8);

        // Reset mid-flight overrides a same-cycle tick.
        press();
        press();
        do_tick();
        chk_yv("fly_again", 232, -8);
        rst = 1'b1; tick = 1'b1;
        step();
        rst = 1'b0; tick = 1'b0;
        chk_yv("midreset", 240, 0);
        chk("midreset_playing", int'(playing), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
